// File: rtl/ex_mem_pipe_pkg.sv
// Shared definitions for the EX->MEM stage register.
//  - default payload widths
//  - control_flow bit positions {mem_read, mem_write, reg_write, mem_to_reg}
//  - occupancy state encoding of the skid controller
package ex_mem_pipe_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int RD_WIDTH_DEF   = 5;
  localparam int CTRL_WIDTH_DEF = 4;

  localparam int CF_MEM_READ  = 3;
  localparam int CF_MEM_WRITE = 2;
  localparam int CF_REG_WRITE = 1;
  localparam int CF_MEM_TO_REG = 0;

  // Encoding equals the number of held entries, so it doubles as occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/pipe_skid_entry.sv
// One storage slot of the skid buffer: a valid bit plus a payload register.
//  clk, rst  : clock, async active-high reset (valid and payload cleared)
//  load_i    : capture data_i and mark valid
//  clear_i   : drop valid (payload kept); wins over load_i
//  data_i    : payload to capture
//  valid_o   : slot holds an entry
//  data_o    : stored payload
module pipe_skid_entry #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM stage register with a 2-entry skid buffer.
// The main slot drives the mem_* outputs; the skid slot absorbs one extra
// entry so that ex_ready_o can come straight from a flop.
//  clk, rst          : clock, async active-high reset
//  flush_i           : kill all held entries at next edge (beats push/pop)
//  ex_valid_i/ex_ready_o, ex_*_i : upstream handshake and payload
//  mem_valid_o/mem_ready_i, mem_*_o : downstream handshake and head payload
//  fwd_rd_o, fwd_reg_write_o : head destination info for forwarding/hazards
//  occupancy_o       : entries held (0..2)
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RD_WIDTH   = RD_WIDTH_DEF,
  parameter int CTRL_WIDTH = CTRL_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [DATA_WIDTH-1:0] ex_alu_result_i,
  input  logic [DATA_WIDTH-1:0] ex_store_data_i,
  input  logic [RD_WIDTH-1:0]   ex_rd_i,
  input  logic [CTRL_WIDTH-1:0] ex_ctrl_i,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [DATA_WIDTH-1:0] mem_alu_result_o,
  output logic [DATA_WIDTH-1:0] mem_store_data_o,
  output logic [RD_WIDTH-1:0]   mem_rd_o,
  output logic [CTRL_WIDTH-1:0] mem_ctrl_o,
  output logic [RD_WIDTH-1:0]   fwd_rd_o,
  output logic                  fwd_reg_write_o,
  output logic [1:0]            occupancy_o
);

  localparam int PW = 2*DATA_WIDTH + RD_WIDTH + CTRL_WIDTH;

  occ_state_e state_d, state_q;
  logic       ready_d, ready_q;
  logic       push, pop;
  logic       main_load, main_clear, main_from_skid;
  logic       skid_load, skid_clear;
  logic       main_valid, skid_valid;
  logic [PW-1:0] ex_pay, main_din, main_dout, skid_dout;

  assign ex_pay   = {ex_alu_result_i, ex_store_data_i, ex_rd_i, ex_ctrl_i};
  assign main_din = main_from_skid ? skid_dout : ex_pay;

  assign push = ex_valid_i & ready_q & ~flush_i;
  assign pop  = main_valid & mem_ready_i & ~flush_i;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush_i) begin
      // Only valids are cleared; payload registers may keep stale data.
      main_clear = 1'b1;
      skid_clear = 1'b1;
      state_d    = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) begin
          main_load = 1'b1;
          state_d   = ST_ONE;
        end
        ST_ONE: begin
          if (push && pop) begin
            main_load = 1'b1;
          end else if (push) begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end else if (pop) begin
            main_clear = 1'b1;
            state_d    = ST_EMPTY;
          end
        end
        ST_FULL: if (pop) begin
          // Skid drains into main; never bypasses it, so order stays FIFO.
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
          state_d        = ST_ONE;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    // Ready is computed from the next state so it is available as a flop
    // output, with no path from mem_ready_i to ex_ready_o.
    ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  pipe_skid_entry #(.W(PW)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load),
    .clear_i (main_clear),
    .data_i  (main_din),
    .valid_o (main_valid),
    .data_o  (main_dout)
  );

  pipe_skid_entry #(.W(PW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  (ex_pay),
    .valid_o (skid_valid),
    .data_o  (skid_dout)
  );

  assign {mem_alu_result_o, mem_store_data_o, mem_rd_o, mem_ctrl_o} = main_dout;

  assign ex_ready_o      = ready_q;
  assign mem_valid_o     = main_valid;
  assign fwd_rd_o        = mem_rd_o;
  // rd=0 is the hardwired zero register: never advertise it as a write.
  assign fwd_reg_write_o = main_valid & mem_ctrl_o[CF_REG_WRITE] & (|mem_rd_o);
  assign occupancy_o     = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule
